// File: rtl/prio_enc_pkg.sv
// Shared glyph table and nibble-to-segment helper for the priority encoder display.
// Segment order {g,f,e,d,c,b,a}, active-low.
package prio_enc_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex2seg(
    input logic [3:0] nib
  );
    logic [6:0] s;
    unique case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/prio_enc_rr_disp_seg7_hex.sv
// One hex digit: nibble to active-low seven-segment code.
// A high blank input turns every segment off.
import prio_enc_pkg::*;

module seg7_hex (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex2seg(nib);
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/prio_enc_rr_disp.sv
// N-line fixed/round-robin priority encoder with registered index and hex readout.
// Define PRIO_ENC_BLANK_EN to blank the digits while valid is low.
import prio_enc_pkg::*;

module prio_enc_rr_disp #(
  parameter  int N = 16,
  localparam int W = $clog2(N),
  localparam int D = (W + 3) / 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic [N-1:0]   x,
  input  logic           ack,
  output logic [W-1:0]   y,
  output logic           valid,
  output logic [7*D-1:0] hex
);

  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   base;
  logic [N-1:0]   rot;
  logic [W-1:0]   pick;
  logic           hit;
  logic [4*D-1:0] y_ext;
  logic           blank;

  // Position i of the rotated view holds request (base - i) mod N.
  function automatic logic [W-1:0] rot_idx(
    input logic [W-1:0] b,
    input int           i
  );
    int t;
    t = int'(b) - i;
    if (t < 0) t = t + N;
    return W'(t);
  endfunction

  // Fixed priority is just a rotation anchored at N-1.
  always_comb begin
    base = mode ? ptr_q : W'(N - 1);
    rot  = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = x[rot_idx(base, i)];
    end
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pick = rot_idx(base, i);
    end
    hit = |x;
  end

  always_comb begin
    y_d     = '0;
    valid_d = 1'b0;
    ptr_d   = ptr_q;
    if (en) begin
      y_d     = hit ? pick : '0;
      valid_d = hit;
      if (mode && ack && valid_q) begin
        ptr_d = (y_q == '0) ? W'(N - 1) : y_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      ptr_q   <= W'(N - 1);
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;

  always_comb begin
    y_ext         = '0;
    y_ext[W-1:0]  = y_q;
  end

`ifdef PRIO_ENC_BLANK_EN
  assign blank = ~valid_q;
`else
  assign blank = 1'b0;
`endif

  for (genvar k = 0; k < D; k++) begin : g_dig
    seg7_hex u_dig (
      .nib   (y_ext[4*k +: 4]),
      .blank (blank),
      .seg   (hex[7*k +: 7])
    );
  end

endmodule
